// File: rtl/dm_subword_mem_pkg.sv
// rtl/dm_subword_mem_pkg.sv - shared op encodings, exception codes and helpers for dm_subword_mem
// Purpose: common constants and decode helpers used by the data memory and its lane unit.
// Contents: dm_op_e (access types), dm_size_e (access width), dm_state_e (FSM states),
//           EXC_* exception codes, is_store() and op_size() decode helpers.
package dm_subword_mem_pkg;

  typedef enum logic [2:0] {
    DM_LW  = 3'd0,
    DM_LH  = 3'd1,
    DM_LHU = 3'd2,
    DM_LB  = 3'd3,
    DM_LBU = 3'd4,
    DM_SW  = 3'd5,
    DM_SH  = 3'd6,
    DM_SB  = 3'd7
  } dm_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } dm_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } dm_state_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  function automatic logic is_store(input dm_op_e op);
    return (op == DM_SW) || (op == DM_SH) || (op == DM_SB);
  endfunction

  function automatic dm_size_e op_size(input dm_op_e op);
    case (op)
      DM_LW, DM_SW:         return SZ_WORD;
      DM_LH, DM_LHU, DM_SH: return SZ_HALF;
      default:              return SZ_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// rtl/dm_lane_unit.sv - combinational byte-lane merge, load extension and alignment check
// Purpose: given the addressed word, produce the store-merged word and the extended load value.
// Ports: op_i (access type), addr_lo_i (byte offset), old_word_i (current memory word),
//        wdata_i (right-aligned store data), st_word_o (merged word), ld_data_o (extended load),
//        misalign_o (offset not aligned to the access size).
module dm_lane_unit
  import dm_subword_mem_pkg::*;
(
  input  dm_op_e      op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] st_word_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o
);

  dm_size_e    size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    size       = op_size(op_i);
    misalign_o = ((size == SZ_WORD) && (addr_lo_i != 2'b00)) ||
                 ((size == SZ_HALF) && addr_lo_i[0]);

    byte_sel = old_word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];

    ld_data_o = 32'h0;
    case (op_i)
      DM_LW:   ld_data_o = old_word_i;
      DM_LH:   ld_data_o = {{16{half_sel[15]}}, half_sel};
      DM_LHU:  ld_data_o = {16'h0, half_sel};
      DM_LB:   ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      DM_LBU:  ld_data_o = {24'h0, byte_sel};
      default: ld_data_o = 32'h0;
    endcase

    // Lanes not covered by the store keep their old contents.
    st_word_o = old_word_i;
    case (op_i)
      DM_SW: st_word_o = wdata_i;
      DM_SH: begin
        if (addr_lo_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else              st_word_o[15:0]  = wdata_i[15:0];
      end
      DM_SB:   st_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      default: st_word_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/dm_subword_mem.sv
// rtl/dm_subword_mem.sv - pipeline data memory with sub-word access, exceptions and latency
// Purpose: word-organised data memory for the MEM stage with byte/half/word loads and stores,
//          AdEL/AdES detection and a fixed LATENCY valid/ready response; prints a store trace.
// Ports: clk, rst (sync, active-high); req_valid/req_ready handshake with req_op, req_addr,
//        req_wdata, req_pc; response resp_valid pulse with resp_rdata, resp_exc, resp_exc_code.
module dm_subword_mem
  import dm_subword_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int LATENCY     = 1,
  parameter int TRACE       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exc_code
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem_q [DEPTH_WORDS];

  dm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fire;

  logic        resp_valid_q;
  logic [31:0] resp_rdata_q, pend_rdata_q;
  logic        resp_exc_q, pend_exc_q;
  logic [4:0]  resp_code_q, pend_code_q;

  dm_op_e      op;
  logic        accept;
  logic        out_of_range;
  logic [IDX_W-1:0] idx;
  logic [31:0] old_word, st_word, ld_data, cur_rdata;
  logic        misalign, exc, store, do_write;
  logic [4:0]  exc_code;

  assign op           = dm_op_e'(req_op);
  assign req_ready    = (state_q == ST_IDLE);
  assign accept       = req_valid && req_ready;
  assign out_of_range = req_addr[31:2] >= 30'(DEPTH_WORDS);
  assign idx          = req_addr[IDX_W+1:2];
  // Out-of-range addresses never touch the array, so feed a harmless zero word.
  assign old_word     = out_of_range ? 32'h0 : mem_q[idx];
  assign store        = is_store(op);
  assign exc          = misalign || out_of_range;
  assign exc_code     = exc ? (store ? EXC_ADES : EXC_ADEL) : EXC_NONE;
  assign cur_rdata    = (exc || store) ? 32'h0 : ld_data;
  assign do_write     = accept && store && !exc;

  dm_lane_unit u_lane (
    .op_i       (op),
    .addr_lo_i  (req_addr[1:0]),
    .old_word_i (old_word),
    .wdata_i    (req_wdata),
    .st_word_o  (st_word),
    .ld_data_o  (ld_data),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // fire marks the edge that launches resp_valid for the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_d = ST_BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            fire = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_exc_q   <= 1'b0;
      resp_code_q  <= EXC_NONE;
      pend_rdata_q <= 32'h0;
      pend_exc_q   <= 1'b0;
      pend_code_q  <= EXC_NONE;
    end else begin
      resp_valid_q <= fire;
      if (do_write) mem_q[idx] <= st_word;
      // The pending copy keeps the visible response fields stable while BUSY.
      if (accept) begin
        pend_rdata_q <= cur_rdata;
        pend_exc_q   <= exc;
        pend_code_q  <= exc_code;
      end
      if (fire) begin
        if (LATENCY > 1) begin
          resp_rdata_q <= pend_rdata_q;
          resp_exc_q   <= pend_exc_q;
          resp_code_q  <= pend_code_q;
        end else begin
          resp_rdata_q <= cur_rdata;
          resp_exc_q   <= exc;
          resp_code_q  <= exc_code;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && (TRACE != 0) && do_write)
      $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, st_word);
  end
`endif

  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_exc      = resp_exc_q;
  assign resp_exc_code = resp_code_q;

endmodule

// File: tb/tb_dm_subword_mem.sv
// tb/tb_dm_subword_mem.sv - directed table-driven bench for dm_subword_mem
module tb_dm_subword_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        v1, rdy1, rv1, ex1;
  logic [2:0]  op1;
  logic [31:0] addr1, wd1, pc1, rd1;
  logic [4:0]  code1;

  logic        v3, rdy3, rv3, ex3;
  logic [2:0]  op3;
  logic [31:0] addr3, wd3, pc3, rd3;
  logic [4:0]  code3;

  dm_subword_mem #(.DEPTH_WORDS(3072), .LATENCY(1), .TRACE(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(rdy1), .req_op(op1), .req_addr(addr1),
    .req_wdata(wd1), .req_pc(pc1),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_exc(ex1), .resp_exc_code(code1)
  );

  dm_subword_mem #(.DEPTH_WORDS(3072), .LATENCY(3), .TRACE(0)) u_l3 (
    .clk(clk), .rst(rst),
    .req_valid(v3), .req_ready(rdy3), .req_op(op3), .req_addr(addr3),
    .req_wdata(wd3), .req_pc(pc3),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_exc(ex3), .resp_exc_code(code3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin
    int cyc;
    logic seen;

    vecs[0]  = '{3'd5, 32'h10,   32'h8765_4321, 32'h0000_0000, 1'b0, 5'd0};
    vecs[1]  = '{3'd3, 32'h11,   32'h0,         32'h0000_0043, 1'b0, 5'd0};
    vecs[2]  = '{3'd1, 32'h12,   32'h0,         32'hFFFF_8765, 1'b0, 5'd0};
    vecs[3]  = '{3'd2, 32'h12,   32'h0,         32'h0000_8765, 1'b0, 5'd0};
    vecs[4]  = '{3'd4, 32'h13,   32'h0,         32'h0000_0087, 1'b0, 5'd0};
    vecs[5]  = '{3'd0, 32'h10,   32'h0,         32'h8765_4321, 1'b0, 5'd0};
    vecs[6]  = '{3'd5, 32'h14,   32'h1122_3344, 32'h0000_0000, 1'b0, 5'd0};
    vecs[7]  = '{3'd7, 32'h15,   32'h0000_00AB, 32'h0000_0000, 1'b0, 5'd0};
    vecs[8]  = '{3'd0, 32'h14,   32'h0,         32'h1122_AB44, 1'b0, 5'd0};
    vecs[9]  = '{3'd6, 32'h16,   32'h0000_CAFE, 32'h0000_0000, 1'b0, 5'd0};
    vecs[10] = '{3'd0, 32'h14,   32'h0,         32'hCAFE_AB44, 1'b0, 5'd0};
    vecs[11] = '{3'd0, 32'h02,   32'h0,         32'h0000_0000, 1'b1, 5'd4};
    vecs[12] = '{3'd5, 32'h20,   32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 5'd0};
    vecs[13] = '{3'd6, 32'h21,   32'h0000_1234, 32'h0000_0000, 1'b1, 5'd5};
    vecs[14] = '{3'd0, 32'h20,   32'h0,         32'hDEAD_BEEF, 1'b0, 5'd0};
    vecs[15] = '{3'd5, 32'h3000, 32'h5555_5555, 32'h0000_0000, 1'b1, 5'd5};
    vecs[16] = '{3'd0, 32'h3000, 32'h0,         32'h0000_0000, 1'b1, 5'd4};
    vecs[17] = '{3'd0, 32'h2FFC, 32'h0,         32'h0000_0000, 1'b0, 5'd0};
    vecs[18] = '{3'd5, 32'h2FFC, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 5'd0};
    vecs[19] = '{3'd0, 32'h2FFC, 32'h0,         32'hA5A5_A5A5, 1'b0, 5'd0};
    vecs[20] = '{3'd3, 32'h17,   32'h0,         32'hFFFF_FFCA, 1'b0, 5'd0};
    vecs[21] = '{3'd1, 32'h03,   32'h0,         32'h0000_0000, 1'b1, 5'd4};
    vecs[22] = '{3'd7, 32'h03,   32'h0000_00FF, 32'h0000_0000, 1'b0, 5'd0};

    rst = 1'b1;
    v1 = 1'b0; op1 = 3'd0; addr1 = 32'h0; wd1 = 32'h0; pc1 = 32'h0;
    v3 = 1'b0; op3 = 3'd0; addr3 = 32'h0; wd3 = 32'h0; pc3 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst ready1", {31'h0, rdy1}, 32'h1);
    chk("rst rvalid1", {31'h0, rv1}, 32'h0);
    chk("rst rdata1", rd1, 32'h0);
    chk("rst exc1", {31'h0, ex1}, 32'h0);
    chk("rst code1", {27'h0, code1}, 32'h0);
    chk("rst ready3", {31'h0, rdy3}, 32'h1);
    chk("rst rvalid3", {31'h0, rv3}, 32'h0);

    // LATENCY=1 table: every response one cycle after accept.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d ready", i), {31'h0, rdy1}, 32'h1);
      v1 = 1'b1; op1 = vecs[i].op; addr1 = vecs[i].addr; wd1 = vecs[i].wdata;
      pc1 = 32'h0040_0000 + 32'(i * 4);
      @(posedge clk);
      #1;
      v1 = 1'b0;
      chk($sformatf("v%0d rvalid", i), {31'h0, rv1}, 32'h1);
      chk($sformatf("v%0d rdata", i), rd1, vecs[i].rdata);
      chk($sformatf("v%0d exc", i), {31'h0, ex1}, {31'h0, vecs[i].exc});
      chk($sformatf("v%0d code", i), {27'h0, code1}, {27'h0, vecs[i].code});
    end

    // SB 0x03 over a zero word, then the word read back; afterwards the response holds.
    @(negedge clk);
    v1 = 1'b1; op1 = 3'd0; addr1 = 32'h0;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    chk("sb03 word", rd1, 32'hFF00_0000);
    @(posedge clk);
    #1;
    chk("pulse end rvalid", {31'h0, rv1}, 32'h0);
    chk("held rdata", rd1, 32'hFF00_0000);

    // LATENCY=3: store accepted, then a load held on req_valid through BUSY.
    @(negedge clk);
    v3 = 1'b1; op3 = 3'd5; addr3 = 32'h40; wd3 = 32'h1357_9BDF; pc3 = 32'h100;
    @(posedge clk);
    #1;
    chk("l3 busy1 ready", {31'h0, rdy3}, 32'h0);
    chk("l3 busy1 rvalid", {31'h0, rv3}, 32'h0);
    op3 = 3'd0; wd3 = 32'h0; pc3 = 32'h104;
    @(posedge clk);
    #1;
    chk("l3 busy2 ready", {31'h0, rdy3}, 32'h0);
    chk("l3 busy2 rvalid", {31'h0, rv3}, 32'h0);
    @(posedge clk);
    #1;
    chk("l3 resp rvalid", {31'h0, rv3}, 32'h1);
    chk("l3 resp ready", {31'h0, rdy3}, 32'h1);
    chk("l3 sw rdata", rd3, 32'h0);
    @(posedge clk);
    #1;
    v3 = 1'b0;
    chk("l3 held accepted", {31'h0, rdy3}, 32'h0);
    chk("l3 pulse end", {31'h0, rv3}, 32'h0);
    cyc = 1;
    while (!rv3 && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("l3 lw latency", 32'(cyc), 32'd3);
    chk("l3 lw rdata", rd3, 32'h1357_9BDF);

    // Reset one cycle into a LATENCY=3 load drops the response and clears memory.
    @(negedge clk);
    v3 = 1'b1; op3 = 3'd0; addr3 = 32'h40;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    seen = rv3;
    @(negedge clk);
    rst = 1'b0;
    chk("post rst ready", {31'h0, rdy3}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (rv3) seen = 1'b1;
    end
    chk("rst dropped resp", {31'h0, seen}, 32'h0);

    @(negedge clk);
    v3 = 1'b1; op3 = 3'd0; addr3 = 32'h40;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    cyc = 1;
    while (!rv3 && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("post rst latency", 32'(cyc), 32'd3);
    chk("post rst rdata", rd3, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
